// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the button-triggered UART sender
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  localparam int DATA_BITS              = 8;
  localparam int DEFAULT_CLKS_PER_BIT   = 868;
  localparam int DEFAULT_DEBOUNCE_TICKS = 10;

endpackage

// File: rtl/debouncer.sv
// rtl/debouncer.sv - 2-flop synchronizer, stability counter and rising-edge pulse
module debouncer #(
  parameter int TICKS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  localparam int CNT_W = $clog2(TICKS + 1);

  logic             sync_1;
  logic             sync_2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_1  <= din;
      sync_2  <= sync_1;
      level_q <= level;
      // Level only follows after TICKS consecutive mismatching cycles.
      if (sync_2 != level) begin
        if (cnt == CNT_W'(TICKS - 1)) begin
          level <= sync_2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/uart_tx_button_sender.sv
// rtl/uart_tx_button_sender.sv - sends SW as one 8N1 frame per debounced BTN[1] press
module uart_tx_button_sender
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] BTN,
  input  logic [7:0] SW,
  input  logic       UART_RXD,
  output logic       UART_TXD,
  output logic [7:0] LED,
  output logic       done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e              state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [2:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   send_req;
  logic                   baud_last;
  logic                   unused_inputs;

  assign unused_inputs = ^{BTN[4:2], BTN[0], UART_RXD};

  debouncer #(
    .TICKS (DEBOUNCE_TICKS)
  ) u_debouncer (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (BTN[1]),
    .rise  (send_req)
  );

  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      UART_TXD <= 1'b1;
      LED      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          UART_TXD <= 1'b1;
          if (send_req) begin
            shift    <= SW;
            LED      <= SW;
            UART_TXD <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            UART_TXD <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            bit_cnt  <= bit_cnt + 3'd1;
            // shift[1] is the next bit because the shift lands this same edge.
            if (bit_cnt == LAST_BIT) begin
              UART_TXD <= 1'b1;
              state    <= STOP;
            end else begin
              UART_TXD <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          UART_TXD <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_button_sender.sv
// tb/tb_uart_tx_button_sender.sv - self-checking bench for uart_tx_button_sender
module tb_uart_tx_button_sender;

  localparam int CPB = 16;
  localparam int DEB = 10;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [4:0] BTN = 5'b10101;
  logic [7:0] SW = 8'h00;
  logic       UART_RXD = 1'b1;
  logic       UART_TXD;
  logic [7:0] LED;
  logic       done;

  always #5 CLK = ~CLK;

  uart_tx_button_sender #(
    .CLKS_PER_BIT   (CPB),
    .DEBOUNCE_TICKS (DEB)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .BTN      (BTN),
    .SW       (SW),
    .UART_RXD (UART_RXD),
    .UART_TXD (UART_TXD),
    .LED      (LED),
    .done     (done)
  );

  typedef struct {
    logic [7:0] sw;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   fails = 0;
  int   done_pulses = 0;
  int   hold_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (done === 1'b1) done_pulses++;
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) BTN[1] = 1'b0;
    end
  endtask

  task automatic press(input int n);
    BTN[1]    = 1'b1;
    hold_left = n;
  endtask

  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic [9:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i + 1] = b[i];
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic wait_fall(input string name);
    int  n = 0;
    bit  seen = 0;
    while (n < 200 && !seen) begin
      tick();
      n++;
      if (UART_TXD === 1'b0) seen = 1;
    end
    check($sformatf("%s latency", name), n, 2 + DEB + 1);
  endtask

  task automatic idle_check(input int n, input string name);
    int lows = 0;
    int dp0 = done_pulses;
    for (int i = 0; i < n; i++) begin
      tick();
      if (UART_TXD !== 1'b1) lows++;
    end
    check($sformatf("%s txd low cycles", name), lows, 0);
    check($sformatf("%s done pulses", name), done_pulses - dp0, 0);
  endtask

  // action: 0 none, 1 change SW, 2 change SW and press again, 3 reset mid-frame
  task automatic check_frame(input logic [9:0] exp, input string name, input int action, input int at);
    int t = 0;
    int bad;
    int dp0 = done_pulses;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (t > 0) tick();
        if (action != 0 && t == at) begin
          SW = ~SW;
          if (action == 2) press(30);
          if (action == 3) begin
            RST_N = 1'b0;
            #1;
            check($sformatf("%s txd async reset", name), UART_TXD, 1);
            check($sformatf("%s done in reset", name), done, 0);
            repeat (3) tick();
            check($sformatf("%s led after reset", name), LED, 8'h00);
            check($sformatf("%s no done on reset", name), done_pulses - dp0, 0);
            RST_N = 1'b1;
            return;
          end
        end
        if (UART_TXD !== exp[b]) bad++;
        t++;
      end
      check($sformatf("%s bit%0d", name, b), bad, 0);
    end
    tick();
    check($sformatf("%s done at end", name), done, 1);
    check($sformatf("%s txd idle at end", name), UART_TXD, 1);
    check($sformatf("%s done count", name), done_pulses - dp0, 1);
    tick();
    check($sformatf("%s done one cycle", name), done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rsw;
    int         act;
    int         dp_start;

    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'h55, 10'h2AA};
    vecs[4] = '{8'h3C, 10'h278};

    repeat (5) tick();
    check("reset txd", UART_TXD, 1);
    check("reset led", LED, 8'h00);
    check("reset done", done, 0);
    RST_N = 1'b1;
    idle_check(100, "post reset idle");

    dp_start = done_pulses;
    for (int i = 0; i < 5; i++) begin
      SW = vecs[i].sw;
      press(50);
      wait_fall($sformatf("vec%0d", i));
      check_frame(vecs[i].frame, $sformatf("vec%0d", i), 0, 0);
      repeat (9) tick();
      check($sformatf("vec%0d led", i), LED, vecs[i].sw);
    end
    check("table done total", done_pulses - dp_start, 5);
    idle_check(100, "after table");

    for (int r = 0; r < 8; r++) begin
      BTN[1] = 1'b1;
      repeat (3) tick();
      BTN[1] = 1'b0;
      repeat (3) tick();
    end
    idle_check(150, "bounce");

    SW = 8'hC3;
    press(50);
    wait_fall("second press");
    check_frame(model_frame(8'hC3), "second press", 2, 60);
    check("second press led", LED, 8'hC3);
    idle_check(100, "second press ignored");

    SW = 8'h96;
    press(50);
    wait_fall("mid reset");
    check_frame(model_frame(8'h96), "mid reset", 3, 80);
    idle_check(20, "after mid reset");
    SW = 8'h6B;
    press(50);
    wait_fall("after reset send");
    check_frame(model_frame(8'h6B), "after reset send", 0, 0);
    check("after reset led", LED, 8'h6B);
    repeat (9) tick();

    for (int i = 0; i < 6; i++) begin
      rsw = 8'($urandom);
      act = $urandom_range(0, 2);
      SW  = rsw;
      press(50);
      wait_fall($sformatf("rand%0d", i));
      check_frame(model_frame(rsw), $sformatf("rand%0d", i), act, $urandom_range(20, 130));
      repeat (9) tick();
      check($sformatf("rand%0d led", i), LED, rsw);
    end
    idle_check(100, "final idle");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_button_sender.md
# uart_tx_button_sender

Board-level UART transmit exerciser: a debounced push-button (BTN[1]) triggers transmission of the 8-bit switch value (SW) as one 8N1 frame on UART_TXD. A one-cycle `done` pulse marks the end of each frame. LED mirrors the last byte sent. The block sits at the FPGA top level, between the board I/O and the serial line.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200 baud). The minimum legal value is 2.
- DEBOUNCE_TICKS, default 10: consecutive cycles that BTN[1] must be stable before the debounced level changes.

Ports:
- CLK  in  1  system clock; all logic sits in this single clock domain.
- RST_N  in  1  reset, asynchronous and active-low.
- BTN  in  5  push-buttons.
  - BTN[1] is the send request.
  - BTN[0] and BTN[4:2] are ignored.
- SW  in  8  byte to transmit; sampled at frame start.
- UART_RXD  in  1  serial receive line; unused and ignored.
- UART_TXD  out  1  serial transmit line; idles high.
- LED  out  8  last byte latched for transmission.
- done  out  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- BTN[1] path:
  - First passes through a 2-flop synchronizer.
  - Then goes through a debouncer. The debounced level takes the new input value once the synchronized input has differed from it for DEBOUNCE_TICKS consecutive cycles. Any mismatch-free cycle resets the counter.
- A send request is a rising edge of the debounced level.
- TX FSM states:
  - IDLE: UART_TXD=1. On a request, latch SW into the shift register and into LED, then go to START.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive shift[0] for CLKS_PER_BIT cycles, shift right, and repeat for 8 bits (LSB first), then go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles, then pulse `done` and return to IDLE.
- Requests that arrive outside IDLE are dropped; there is no queueing.
- A held button produces one frame only; the next frame needs a release followed by a new press.
- Changes to SW during a frame do not affect the frame in progress.

## Timing
- Reset values (async assert, release synchronous to CLK):
  - UART_TXD=1, LED=0x00, done=0.
  - FSM=IDLE; bit counter, baud counter and debounce counter all 0; debounced level 0.
- Request latency:
  - From BTN[1] rising: 2 synchronizer cycles plus DEBOUNCE_TICKS cycles until the debounced rise.
  - The START state (TXD falling) begins on the next clock edge after the debounced rise.
- Frame length: exactly 10×CLKS_PER_BIT cycles from TXD falling to the end of the stop bit.
- `done`:
  - High for exactly one cycle, in the cycle the FSM re-enters IDLE.
  - A new frame can start on the following cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and is cleared at every state entry. The bit counter is 3 bits and wraps 7→0 on leaving DATA.
- A request in the same cycle as `done` is ignored, because the FSM is not yet in IDLE.
- Reset mid-frame: TXD returns to 1 immediately (asynchronously), and the FSM enters IDLE with no `done` pulse.
- A button bounce shorter than DEBOUNCE_TICKS cycles produces no request.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum {IDLE, START, DATA, STOP};
  - the constants DATA_BITS=8 and the defaults for CLKS_PER_BIT and DEBOUNCE_TICKS.
- One natural sub-module, `debouncer`, containing the synchronizer, the stability counter and the rising-edge output.
- The TX FSM and baud counter live in the top level.

## Test plan
Benches use CLKS_PER_BIT=16 and a 10 ns clock.
- Reset: hold RST_N=0 for 5 cycles -> UART_TXD=1, LED=0x00, done=0. Release -> the line stays idle for 100 cycles.
- Single send: SW=0xA5, BTN[1] high for 50 cycles.
  - TXD falls 2+10+1 cycles after the press.
  - Bits, 16 cycles each: 0,1,0,1,0,0,1,0,1,1.
  - LED=0xA5; done pulses once, 160 cycles after TXD falls.
- Four back-to-back sends (SW=0x00, 0xFF, 0x55, 0x3C), each with a 50-cycle press, then wait for `done` plus 10 cycles -> four correct frames and four done pulses. TXD is high for 100 cycles after the last frame.
- Bounce: BTN[1] toggled with high periods of 3 cycles, then held low -> no frame, and TXD stays 1.
- Press during a frame:
  - A second press while in DATA is ignored: exactly one frame, one done pulse.
  - Changing SW mid-frame does not alter the transmitted bits.
- Reset mid-frame: assert RST_N in DATA -> TXD=1 at once, no done pulse. A press after release sends a full frame.
